ped_request_conditioner: RTL



---
 rtl/ped_request_conditioner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ped_request_conditioner.sv
// Pedestrian button conditioner: sync, debounce, edge-detect, hold request until green, pulse pass, cooldown.
// Optional build macro PED_QUEUE_EN adds a one-deep queue for presses arriving during ISSUE/COOL.
module ped_request_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int COOLDOWN   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       green,
  output logic       pass,
  output logic       req_pending,
  output logic       busy,
  output logic [1:0] fsm_state
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ISSUE = 2'd2,
    COOL  = 2'd3
  } state_t;

  logic          s1, s2;
  logic          btn_db, btn_db_d;
  logic [DW-1:0] deb_cnt;
  logic          press;
  state_t        state, state_next;
  logic [CW-1:0] cool_cnt, cool_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // The debounced level only moves after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_db_d <= btn_db;
      if (s2 != btn_db) begin
        if (deb_cnt == DEB_LAST) begin
          btn_db  <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_d;

`ifdef PED_QUEUE_EN
  logic queued, queued_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) queued <= 1'b0;
    else       queued <= queued_next;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cool_cnt <= '0;
    end else begin
      state    <= state_next;
      cool_cnt <= cool_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    cool_next  = cool_cnt;
`ifdef PED_QUEUE_EN
    queued_next = queued;
`endif
    case (state)
      IDLE:  if (press) state_next = ARMED;
      ARMED: if (green) state_next = ISSUE;
      ISSUE: begin
        state_next = COOL;
        cool_next  = COOL_LOAD;
`ifdef PED_QUEUE_EN
        if (press) queued_next = 1'b1;
`endif
      end
      COOL: begin
        if (cool_cnt == '0) begin
`ifdef PED_QUEUE_EN
          // A press landing on the exit cycle is honoured the same as an earlier queued one.
          if (queued || press) state_next = ARMED;
          else                 state_next = IDLE;
          queued_next = 1'b0;
`else
          state_next = IDLE;
`endif
        end else begin
          cool_next = cool_cnt - CW'(1);
`ifdef PED_QUEUE_EN
          if (press) queued_next = 1'b1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pass        = (state == ISSUE);
  assign req_pending = (state == ARMED);
  assign busy        = (state == ISSUE) || (state == COOL);
  assign fsm_state   = state;

endmodule
